// File: rtl/vec_join_tile_sched.sv
// vec_join_tile_sched: credit-bounded lambda/x_t tile request sequencer for one SSM scan pass; optional VEC_JOIN_SCHED_PERF_EN stall counters
module vec_join_tile_sched #(
  parameter int NUM_TILES  = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int T_W        = 16,
  parameter int TILE_W     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [T_W-1:0]    seq_len,
  output logic              busy,
  output logic              done,
  output logic              a_req_valid,
  input  logic              a_req_ready,
  output logic [T_W-1:0]    a_req_t,
  output logic [TILE_W-1:0] a_req_tile,
  output logic              b_req_valid,
  input  logic              b_req_ready,
  output logic [T_W-1:0]    b_req_t,
  output logic [TILE_W-1:0] b_req_tile,
  input  logic              join_pop,
  output logic [T_W-1:0]    pop_t,
  output logic [TILE_W-1:0] pop_tile
`ifdef VEC_JOIN_SCHED_PERF_EN
  ,
  output logic [31:0]       perf_a_stall,
  output logic [31:0]       perf_b_stall,
  output logic [31:0]       perf_cred_stall
`endif
);
  localparam int TOT_W = T_W + TILE_W;
  localparam int C_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [TILE_W-1:0] LAST = TILE_W'(NUM_TILES - 1);
  localparam logic [C_W-1:0] FULL = C_W'(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic [TOT_W-1:0] total_q, total_d, a_iss_q, a_iss_d, b_iss_q, b_iss_d, pop_cnt_q, pop_cnt_d;
  logic [C_W-1:0] a_cred_q, a_cred_d, b_cred_q, b_cred_d;
  logic [T_W-1:0] a_t_q, a_t_d, b_t_q, b_t_d, p_t_q, p_t_d;
  logic [TILE_W-1:0] a_tile_q, a_tile_d, b_tile_q, b_tile_d, p_tile_q, p_tile_d;
  logic a_fire, b_fire, pop_ok;
  assign busy = (state_q == ISSUE) || (state_q == DRAIN);
  assign done = state_q == DONE;
  assign a_req_valid = (state_q == ISSUE) && (a_iss_q < total_q) && (a_cred_q < FULL);
  assign b_req_valid = (state_q == ISSUE) && (b_iss_q < total_q) && (b_cred_q < FULL);
  assign a_fire = a_req_valid && a_req_ready;
  assign b_fire = b_req_valid && b_req_ready;
  assign pop_ok = join_pop && busy;
  assign a_req_t = a_t_q;
  assign a_req_tile = a_tile_q;
  assign b_req_t = b_t_q;
  assign b_req_tile = b_tile_q;
  assign pop_t = p_t_q;
  assign pop_tile = p_tile_q;
  // index/credit bookkeeping and pass sequencing; a pass ends once every issued tile has been popped
  always_comb begin
    state_d = state_q;
    total_d = total_q;
    a_iss_d = a_iss_q + TOT_W'(a_fire);
    b_iss_d = b_iss_q + TOT_W'(b_fire);
    pop_cnt_d = pop_cnt_q + TOT_W'(pop_ok);
    a_tile_d = a_fire ? ((a_tile_q == LAST) ? '0 : a_tile_q + TILE_W'(1)) : a_tile_q;
    a_t_d = (a_fire && a_tile_q == LAST) ? a_t_q + T_W'(1) : a_t_q;
    b_tile_d = b_fire ? ((b_tile_q == LAST) ? '0 : b_tile_q + TILE_W'(1)) : b_tile_q;
    b_t_d = (b_fire && b_tile_q == LAST) ? b_t_q + T_W'(1) : b_t_q;
    p_tile_d = pop_ok ? ((p_tile_q == LAST) ? '0 : p_tile_q + TILE_W'(1)) : p_tile_q;
    p_t_d = (pop_ok && p_tile_q == LAST) ? p_t_q + T_W'(1) : p_t_q;
    a_cred_d = (a_fire && !pop_ok) ? a_cred_q + C_W'(1) :
               (!a_fire && pop_ok && a_cred_q != '0) ? a_cred_q - C_W'(1) : a_cred_q;
    b_cred_d = (b_fire && !pop_ok) ? b_cred_q + C_W'(1) :
               (!b_fire && pop_ok && b_cred_q != '0) ? b_cred_q - C_W'(1) : b_cred_q;
    case (state_q)
      IDLE: begin
        if (start && seq_len == '0) begin
          state_d = DONE;
        end else if (start) begin
          state_d = ISSUE;
          total_d = TOT_W'(seq_len) * TOT_W'(NUM_TILES);
          a_iss_d = '0;
          b_iss_d = '0;
          pop_cnt_d = '0;
          a_cred_d = '0;
          b_cred_d = '0;
          a_t_d = '0;
          a_tile_d = '0;
          b_t_d = '0;
          b_tile_d = '0;
          p_t_d = '0;
          p_tile_d = '0;
        end
      end
      ISSUE: begin
        if (a_iss_d == total_q && b_iss_d == total_q)
          state_d = (pop_cnt_d == total_q) ? DONE : DRAIN;
      end
      DRAIN: state_d = (pop_cnt_d == total_q) ? DONE : DRAIN;
      default: state_d = IDLE;
    endcase
  end
  // state and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      total_q <= '0;
      a_iss_q <= '0;
      b_iss_q <= '0;
      pop_cnt_q <= '0;
      a_cred_q <= '0;
      b_cred_q <= '0;
      a_t_q <= '0;
      a_tile_q <= '0;
      b_t_q <= '0;
      b_tile_q <= '0;
      p_t_q <= '0;
      p_tile_q <= '0;
    end else begin
      state_q <= state_d;
      total_q <= total_d;
      a_iss_q <= a_iss_d;
      b_iss_q <= b_iss_d;
      pop_cnt_q <= pop_cnt_d;
      a_cred_q <= a_cred_d;
      b_cred_q <= b_cred_d;
      a_t_q <= a_t_d;
      a_tile_q <= a_tile_d;
      b_t_q <= b_t_d;
      b_tile_q <= b_tile_d;
      p_t_q <= p_t_d;
      p_tile_q <= p_tile_d;
    end
  end
`ifdef VEC_JOIN_SCHED_PERF_EN
  logic [31:0] perf_a_q, perf_b_q, perf_c_q;
  logic cred_block;
  assign cred_block = (state_q == ISSUE) &&
                      (((a_iss_q < total_q) && (a_cred_q == FULL)) || ((b_iss_q < total_q) && (b_cred_q == FULL)));
  assign perf_a_stall = perf_a_q;
  assign perf_b_stall = perf_b_q;
  assign perf_cred_stall = perf_c_q;
  // stall counters: cleared on an accepted start, frozen outside ISSUE
  always_ff @(posedge clk) begin
    if (rst || (state_q == IDLE && start)) begin
      perf_a_q <= '0;
      perf_b_q <= '0;
      perf_c_q <= '0;
    end else begin
      perf_a_q <= perf_a_q + 32'(a_req_valid && !a_req_ready);
      perf_b_q <= perf_b_q + 32'(b_req_valid && !b_req_ready);
      perf_c_q <= perf_c_q + 32'(cred_block);
    end
  end
`endif
endmodule

// File: tb/tb_vec_join_tile_sched.sv
// tb_vec_join_tile_sched: random and directed stimulus checked every cycle against a tile-count reference model
module tb_vec_join_tile_sched;
  localparam int NT = 4;
  localparam int D = 4;
  localparam int TW = 16;
  localparam int TLW = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [TW-1:0] seq_len = '0;
  logic a_req_ready = 1'b0;
  logic b_req_ready = 1'b0;
  logic join_pop = 1'b0;
  logic busy, done, a_req_valid, b_req_valid;
  logic [TW-1:0] a_req_t, b_req_t, pop_t;
  logic [TLW-1:0] a_req_tile, b_req_tile, pop_tile;
`ifdef VEC_JOIN_SCHED_PERF_EN
  logic [31:0] perf_a_stall, perf_b_stall, perf_cred_stall;
`endif

  vec_join_tile_sched #(.NUM_TILES(NT), .FIFO_DEPTH(D), .T_W(TW), .TILE_W(TLW)) dut (
    .clk(clk), .rst(rst), .start(start), .seq_len(seq_len), .busy(busy), .done(done),
    .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_t(a_req_t), .a_req_tile(a_req_tile),
    .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_t(b_req_t), .b_req_tile(b_req_tile),
    .join_pop(join_pop), .pop_t(pop_t), .pop_tile(pop_tile)
`ifdef VEC_JOIN_SCHED_PERF_EN
    , .perf_a_stall(perf_a_stall), .perf_b_stall(perf_b_stall), .perf_cred_stall(perf_cred_stall)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  // reference model: mode 0 idle, 1 pass in progress, 2 done cycle; streams tracked as tile counts
  int mode = 0, m_total = 0, m_an = 0, m_bn = 0, m_pop = 0, m_ac = 0, m_bc = 0;
  int m_pa = 0, m_pb = 0, m_pc = 0;
  int a_fires = 0, b_fires = 0, dones = 0;
  int a0, b0, d0;
  bit pop_en = 0, pop_rand = 0, a_rand = 0, b_rand = 0, a_fix = 0, b_fix = 0;

  task automatic chk(input string nm, input longint act, input longint req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  function automatic bit exp_av();
    return mode == 1 && m_an < m_total && m_ac < D;
  endfunction

  function automatic bit exp_bv();
    return mode == 1 && m_bn < m_total && m_bc < D;
  endfunction

  always @(posedge clk) begin
    bit va, vb, fa, fb, pp;
    if (rst) begin
      mode = 0; m_total = 0; m_an = 0; m_bn = 0; m_pop = 0; m_ac = 0; m_bc = 0;
      m_pa = 0; m_pb = 0; m_pc = 0;
    end else if (mode == 0) begin
      if (start) begin
        m_pa = 0; m_pb = 0; m_pc = 0;
        if (seq_len == 0) mode = 2;
        else begin
          m_total = int'(seq_len) * NT;
          m_an = 0; m_bn = 0; m_pop = 0; m_ac = 0; m_bc = 0;
          mode = 1;
        end
      end
    end else if (mode == 1) begin
      va = exp_av();
      vb = exp_bv();
      fa = va && a_req_ready;
      fb = vb && b_req_ready;
      pp = join_pop;
      if (va && !a_req_ready) m_pa++;
      if (vb && !b_req_ready) m_pb++;
      if ((m_an < m_total && m_ac == D) || (m_bn < m_total && m_bc == D)) m_pc++;
      m_an += int'(fa);
      m_bn += int'(fb);
      m_ac = (fa && !pp) ? m_ac + 1 : (!fa && pp && m_ac > 0) ? m_ac - 1 : m_ac;
      m_bc = (fb && !pp) ? m_bc + 1 : (!fb && pp && m_bc > 0) ? m_bc - 1 : m_bc;
      m_pop += int'(pp);
      if (m_pop == m_total) mode = 2;
    end else mode = 0;
  end

  always @(posedge clk) begin
    if (!rst) begin
      a_fires += int'(a_req_valid && a_req_ready);
      b_fires += int'(b_req_valid && b_req_ready);
      dones += int'(done);
    end
  end

  always @(negedge clk) begin
    chk("busy", busy, mode == 1);
    chk("done", done, mode == 2);
    chk("a_valid", a_req_valid, exp_av());
    chk("b_valid", b_req_valid, exp_bv());
    chk("a_t", a_req_t, m_an / NT);
    chk("a_tile", a_req_tile, m_an % NT);
    chk("b_t", b_req_t, m_bn / NT);
    chk("b_tile", b_req_tile, m_bn % NT);
    chk("pop_t", pop_t, m_pop / NT);
    chk("pop_tile", pop_tile, m_pop % NT);
`ifdef VEC_JOIN_SCHED_PERF_EN
    chk("perf_a", perf_a_stall, m_pa);
    chk("perf_b", perf_b_stall, m_pb);
    chk("perf_cred", perf_cred_stall, m_pc);
`endif
  end

  task automatic tick();
    a_req_ready = a_rand ? ($urandom % 4 != 0) : a_fix;
    b_req_ready = b_rand ? ($urandom % 4 != 0) : b_fix;
    join_pop = pop_en && mode == 1 && m_ac > 0 && m_bc > 0 && (!pop_rand || $urandom % 2 == 1);
    @(negedge clk);
  endtask

  task automatic wait_done_seen(input int n);
    int k = 0;
    while (!done && k < n) begin
      tick();
      k++;
    end
    chk("done_seen", done, 1);
  endtask

  task automatic mark();
    a0 = a_fires;
    b0 = b_fires;
    d0 = dones;
  endtask

  task automatic go(input int sl);
    start = 1'b1;
    seq_len = TW'(sl);
    tick();
    start = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int k;
    @(negedge clk);
    repeat (2) tick();
    chk("rst_busy", busy, 0);
    chk("rst_a_valid", a_req_valid, 0);
    chk("rst_b_valid", b_req_valid, 0);
    chk("rst_a_t", a_req_t, 0);
    chk("rst_pop_tile", pop_tile, 0);
    rst = 1'b0;
    a_fix = 1; b_fix = 1; pop_en = 1;
    mark();
    go(2);
    wait_done_seen(40);
    chk("t1_busy_at_done", busy, 0);
    chk("t1_pop_t", pop_t, 2);
    start = 1'b1; seq_len = 3;
    tick();
    start = 1'b0;
    repeat (3) tick();
    chk("t1_start_in_done_ignored", busy, 0);
    chk("t1_a_fires", a_fires - a0, 8);
    chk("t1_b_fires", b_fires - b0, 8);
    chk("t1_dones", dones - d0, 1);
    pop_en = 0;
    mark();
    go(2);
    repeat (15) tick();
    chk("t2_a_fires", a_fires - a0, 4);
    chk("t2_b_fires", b_fires - b0, 4);
    chk("t2_a_valid_low", a_req_valid, 0);
    chk("t2_b_valid_low", b_req_valid, 0);
    pop_en = 1;
    tick();
    pop_en = 0;
    repeat (5) tick();
    chk("t2_a_one_more", a_fires - a0, 5);
    chk("t2_b_one_more", b_fires - b0, 5);
    pop_en = 1;
    wait_done_seen(60);
    tick();
    b_fix = 0;
    mark();
    go(2);
    repeat (10) tick();
    chk("t3_a_fires", a_fires - a0, 4);
    chk("t3_b_fires", b_fires - b0, 0);
    chk("t3_no_pops", pop_tile, 0);
    b_fix = 1;
    wait_done_seen(60);
    tick();
    chk("t3_b_total", b_fires - b0, 8);
    mark();
    go(0);
    chk("z_done", done, 1);
    chk("z_valid", a_req_valid, 0);
    tick();
    chk("z_done_clear", done, 0);
    chk("z_no_fires", a_fires - a0, 0);
    chk("z_dones", dones - d0, 1);
    mark();
    go(1);
    tick();
    tick();
    go(5);
    wait_done_seen(40);
    tick();
    chk("busy_start_dones", dones - d0, 1);
    chk("busy_start_a_fires", a_fires - a0, 4);
    chk("busy_start_pop_t", pop_t, 1);
    pop_en = 0;
    mark();
    go(2);
    k = 0;
    while (a_fires - a0 < 3 && k < 20) begin
      tick();
      k++;
    end
    chk("r_fires", a_fires - a0, 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("r_busy", busy, 0);
    chk("r_done", done, 0);
    chk("r_a_valid", a_req_valid, 0);
    chk("r_b_valid", b_req_valid, 0);
    chk("r_a_t", a_req_t, 0);
    chk("r_a_tile", a_req_tile, 0);
    tick();
    chk("r_no_done", dones - d0, 0);
    mark();
    pop_en = 1;
    go(2);
    wait_done_seen(40);
    tick();
    chk("r_clean_a", a_fires - a0, 8);
    chk("r_clean_b", b_fires - b0, 8);
`ifdef VEC_JOIN_SCHED_PERF_EN
    b_fix = 0;
    go(2);
    repeat (5) tick();
    b_fix = 1;
    wait_done_seen(60);
    tick();
    chk("perf_b_is_5", perf_b_stall, 5);
    chk("perf_a_is_0", perf_a_stall, 0);
    go(1);
    chk("perf_b_cleared", perf_b_stall, 0);
    wait_done_seen(40);
    tick();
`endif
    a_rand = 1; b_rand = 1; pop_rand = 1; pop_en = 1;
    repeat (25) begin
      go($urandom_range(1, 4));
      repeat ($urandom_range(0, 3)) begin
        start = 1'($urandom % 2);
        seq_len = 7;
        tick();
      end
      start = 1'b0;
      wait_done_seen(400);
      tick();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
